// File: rtl/dt_vote_pkg.sv
// Shared types for the decision-tree majority-vote stage (dt_vote_accum).
package dt_vote_pkg;

    typedef logic [1:0] class_t;

    localparam int NUM_CLASSES = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/dt_vote_argmax.sv
// Combinational argmax over the four per-class vote counts.
// Lowest index wins a tie, and o_tie flags that two or more classes share the maximum.
module dt_vote_argmax
    import dt_vote_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [NUM_CLASSES-1:0][CNT_W-1:0] i_cnt,
    output class_t                            o_class,
    output logic                              o_tie
);

    logic [CNT_W-1:0] w_max;
    class_t           w_idx;
    logic [2:0]       w_nmax;

    always_comb begin
        w_max = i_cnt[0];
        w_idx = '0;
        // Strict greater-than keeps the earliest (lowest) index on equal counts
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (i_cnt[k] > w_max) begin
                w_max = i_cnt[k];
                w_idx = class_t'(k);
            end
        end
        w_nmax = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (i_cnt[k] == w_max) begin
                w_nmax = w_nmax + 3'd1;
            end
        end
    end

    assign o_class = w_idx;
    assign o_tie   = (w_nmax > 3'd1);

endmodule

// File: rtl/dt_vote_accum.sv
// Majority-vote accumulator: counts WINDOW classifier decisions, then emits the argmax.
// Optional `DT_VOTE_FLUSH_EN adds a flush input and an out_nsamp output for partial windows.
module dt_vote_accum
    import dt_vote_pkg::*;
#(
    parameter  int WINDOW = 16,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic             out_tie
`ifdef DT_VOTE_FLUSH_EN
    ,
    input  logic             flush,
    output logic [CNT_W-1:0] out_nsamp
`endif
);

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic                             r_live;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0]                 r_nsamp;
    logic [CNT_W-1:0]                 w_nsamp_inc;
    logic [1:0]                       r_out_class;
    logic                             r_out_tie;
    class_t                           w_win_class;
    logic                             w_win_tie;
    logic                             w_acc;
    logic                             w_full;
    logic                             w_flush;
    logic                             w_close;

    assign w_acc = in_valid && in_ready;

    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            w_cnt_inc[k] = r_cnt[k] + CNT_W'(w_acc && (in_class == class_t'(k)));
        end
    end

    assign w_nsamp_inc = r_nsamp + CNT_W'(w_acc);
    assign w_full      = w_acc && (r_nsamp == CNT_W'(WINDOW - 1));

`ifdef DT_VOTE_FLUSH_EN
    // A sample accepted on the flush cycle counts toward the partial window
    assign w_flush = (r_state == ACCUM) && flush && (w_nsamp_inc != '0);
`else
    assign w_flush = 1'b0;
`endif

    assign w_close = w_full || w_flush;

    dt_vote_argmax #(
        .CNT_W   (CNT_W)
    ) u_argmax (
        .i_cnt   (w_cnt_inc),
        .o_class (w_win_class),
        .o_tie   (w_win_tie)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_close)   w_state_nxt = EMIT;
            EMIT:    if (out_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // r_live keeps in_ready low while reset is held, even though the state is ACCUM
    always_comb begin
        in_ready  = r_live && (r_state == ACCUM);
        out_valid = (r_state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_nsamp     <= '0;
            r_out_class <= '0;
            r_out_tie   <= 1'b0;
        end else if (r_state == ACCUM) begin
            r_cnt   <= w_cnt_inc;
            r_nsamp <= w_nsamp_inc;
            if (w_close) begin
                r_out_class <= w_win_class;
                r_out_tie   <= w_win_tie;
            end
        end else if (out_ready) begin
            r_cnt   <= '0;
            r_nsamp <= '0;
        end
    end

    assign out_class = r_out_class;
    assign out_tie   = r_out_tie;

`ifdef DT_VOTE_FLUSH_EN
    logic [CNT_W-1:0] r_out_nsamp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_nsamp <= '0;
        end else if ((r_state == ACCUM) && w_close) begin
            r_out_nsamp <= w_nsamp_inc;
        end
    end

    assign out_nsamp = r_out_nsamp;
`endif

endmodule

// File: tb/tb_dt_vote_accum.sv
// Scoreboard bench for dt_vote_accum (WINDOW=4 main instance plus a WINDOW=1 instance).
// Build with +define+DT_VOTE_FLUSH_EN to also exercise the flush feature.
module tb_dt_vote_accum;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic [1:0] cls;
        logic       tie;
        int         n;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [1:0]    cls = '0;
    logic          rdy_in;
    logic          ovalid;
    logic          oready = 1'b1;
    logic [1:0]    ocls;
    logic          otie;
    logic          flush = 1'b0;
    logic [CW-1:0] onsamp;

    logic          v1 = 1'b0;
    logic [1:0]    c1 = '0;
    logic          ir1;
    logic          ov1;
    logic          or1 = 1'b1;
    logic [1:0]    oc1;
    logic          ot1;
    logic          flush1 = 1'b0;
    logic [0:0]    ons1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    bit   rand_ordy = 0;
    bit   last_acc;
    int   samples[$];
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dt_vote_accum #(.WINDOW(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (valid),
        .in_ready  (rdy_in),
        .in_class  (cls),
        .out_valid (ovalid),
        .out_ready (oready),
        .out_class (ocls),
        .out_tie   (otie)
`ifdef DT_VOTE_FLUSH_EN
        ,
        .flush     (flush),
        .out_nsamp (onsamp)
`endif
    );

    dt_vote_accum #(.WINDOW(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (ir1),
        .in_class  (c1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_class (oc1),
        .out_tie   (ot1)
`ifdef DT_VOTE_FLUSH_EN
        ,
        .flush     (flush1),
        .out_nsamp (ons1)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference vote: count each class in the window, first class with the top count wins
    function automatic exp_t ref_vote(input int s[$]);
        int   cnt[4];
        int   best;
        int   nbest;
        exp_t e;
        cnt = '{0, 0, 0, 0};
        foreach (s[i]) cnt[s[i]]++;
        best = 0;
        for (int c = 1; c < 4; c++) if (cnt[c] > cnt[best]) best = c;
        nbest = 0;
        for (int c = 0; c < 4; c++) if (cnt[c] == cnt[best]) nbest++;
        e.cls = 2'(best);
        e.tie = (nbest > 1);
        e.n   = s.size();
        e.cyc = 0;
        return e;
    endfunction

    task automatic step(input bit v, input logic [1:0] c, input bit fl);
        exp_t e;
        bit   fl_eff;
        fl_eff = fl;
`ifndef DT_VOTE_FLUSH_EN
        fl_eff = 1'b0;
`endif
        @(posedge clk); #1;
        valid = v;
        cls   = c;
        flush = fl;
        last_acc = v && rdy_in;
        if (last_acc) samples.push_back(int'(c));
        if (samples.size() == W || (fl_eff && rdy_in && samples.size() > 0)) begin
            e     = ref_vote(samples);
            e.cyc = cyc;
            sbq.push_back(e);
            samples.delete();
            n_pushed++;
        end
    endtask

    task automatic send(input logic [1:0] c);
        for (int t = 0; t < 60; t++) begin
            step(1'b1, c, 1'b0);
            if (last_acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) step(1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        valid = 1'b0;
        flush = 1'b0;
        samples.delete();
        sbq.delete();
        @(posedge clk); #1;
        chk("rst_out_valid", ovalid, 0);
        chk("rst_in_ready", rdy_in, 0);
        chk("rst_out_class", ocls, 0);
        chk("rst_out_tie", otie, 0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() > 0; t++) idle(1);
        chk("drain_empty", sbq.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ordy) oready = 1'($urandom_range(0, 1));
    end

    bit         prev_ov = 0;
    bit         prev_ordy = 0;
    logic [1:0] held_cls = '0;
    logic       held_tie = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ov = 0;
        end else begin
            if (ovalid) chk("no_accept_in_emit", rdy_in, 0);
            if (ovalid && !prev_ov) begin
                if (sbq.size() == 0) chk("unexpected_out", 1, 0);
                else                 chk("latency", cyc, sbq[0].cyc + 1);
            end
            if (ovalid && prev_ov && !prev_ordy) begin
                chk("hold_class", ocls, held_cls);
                chk("hold_tie", otie, held_tie);
            end
            if (ovalid && oready && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_class", ocls, e.cls);
                chk("out_tie", otie, e.tie);
`ifdef DT_VOTE_FLUSH_EN
                chk("out_nsamp", onsamp, e.n);
`endif
                n_popped++;
            end
            prev_ov   = ovalid;
            prev_ordy = oready;
            held_cls  = ocls;
            held_tie  = otie;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_in_ready", rdy_in, 0);
        chk("init_out_valid", ovalid, 0);
        rst_n = 1'b1;
        idle(1);

        // WINDOW=1: one result per accepted sample, one every two cycles
        v1 = 1'b1; c1 = 2'd3;
        chk("w1_ready0", ir1, 1);
        @(posedge clk); #1;
        chk("w1_valid_a", ov1, 1);
        chk("w1_class_a", oc1, 3);
        chk("w1_tie_a", ot1, 0);
        chk("w1_busy", ir1, 0);
        c1 = 2'd0;
        @(posedge clk); #1;
        chk("w1_gap", ov1, 0);
        chk("w1_ready1", ir1, 1);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("w1_valid_b", ov1, 1);
        chk("w1_class_b", oc1, 0);
        chk("w1_tie_b", ot1, 0);

        // Clear winner, in_valid held high
        oready = 1'b1;
        send(2'd1); send(2'd1); send(2'd2); send(2'd3);
        idle(1);
        chk("t1_valid", ovalid, 1);
        idle(2);

        // Tie resolved to lowest index, output stalled three cycles
        oready = 1'b0;
        send(2'd2); send(2'd0); send(2'd0); send(2'd2);
        idle(1);
        chk("t2_valid", ovalid, 1);
        idle(3);
        oready = 1'b1;
        idle(1);
        chk("t2_ready_after", rdy_in, 1);
        chk("t2_valid_fall", ovalid, 0);
        idle(1);

        // Reset mid-window discards partial counts
        send(2'd1); send(2'd3);
        do_reset();
        send(2'd2); send(2'd2); send(2'd2); send(2'd2);
        idle(3);
        chk("t4_results", n_popped, n_pushed);

`ifdef DT_VOTE_FLUSH_EN
        send(2'd3); send(2'd3); send(2'd1);
        step(1'b0, 2'd0, 1'b1);
        idle(3);
        drain();
        step(1'b0, 2'd0, 1'b1);
        idle(3);
        chk("flush_empty_no_out", ovalid, 0);
`endif

        // Random traffic with random back-pressure
        rand_ordy = 1;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
        end
        idle(1);
        rand_ordy = 0;
        #1 oready = 1'b1;
        drain();
        chk("all_results", n_popped, n_pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
